edge_detector_multi: RTL and testbench



---
 rtl/edge_detector_multi_pkg.sv | 23 ++
 rtl/edge_debounce_ch.sv | 105 ++++++++++
 rtl/edge_detector_multi.sv | 55 +++++
 tb/tb_edge_detector_multi.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detector_multi_pkg.sv
// -----------------------------------------------------------------------------
// edge_detector_multi_pkg
// Shared constants and helpers for the multi-channel edge detector:
//   TRUE / FALSE         - single-bit logic constants
//   DEFAULT_SYNC_STAGES  - default synchroniser depth
//   cnt_width()          - debounce counter width, never narrower than 1 bit
// -----------------------------------------------------------------------------
package edge_detector_multi_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // The counter only has to reach DEBOUNCE_CYCLES-1. A single-cycle filter
    // still needs a 1-bit counter so the register is never zero width.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_debounce_ch.sv
// -----------------------------------------------------------------------------
// edge_debounce_ch
// One channel of the edge detector: synchroniser chain, debounce counter,
// filtered level, registered edge pulses and sticky event flags.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   in_i           - raw asynchronous input
//   clear_pos_i    - clears event_pos_o at a clock edge (a new set wins)
//   clear_neg_i    - clears event_neg_o at a clock edge (a new set wins)
//   level_o        - debounced, synchronised level
//   posedge_o      - one-cycle pulse on accepted 0->1
//   negedge_o      - one-cycle pulse on accepted 1->0
//   event_pos_o    - sticky posedge flag
//   event_neg_o    - sticky negedge flag
// -----------------------------------------------------------------------------
module edge_debounce_ch
    import edge_detector_multi_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    input  logic clear_pos_i,
    input  logic clear_neg_i,
    output logic level_o,
    output logic posedge_o,
    output logic negedge_o,
    output logic event_pos_o,
    output logic event_neg_o
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pos_q, pos_d;
    logic          neg_q, neg_d;
    logic          ev_pos_q, ev_pos_d;
    logic          ev_neg_q, ev_neg_d;
    logic          accept;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        level_d = level_q;
        cnt_d   = cnt_q;
        accept  = FALSE;

        // Any return to the accepted level discards the partial count.
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = synced;
            cnt_d   = '0;
            accept  = TRUE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        pos_d = accept & synced;
        neg_d = accept & ~synced;

        // A flag being set on the same edge as its clear stays set.
        ev_pos_d = pos_d | (ev_pos_q & ~clear_pos_i);
        ev_neg_d = neg_d | (ev_neg_q & ~clear_neg_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= {SYNC_STAGES{INIT_LEVEL}};
            level_q  <= INIT_LEVEL;
            cnt_q    <= '0;
            pos_q    <= FALSE;
            neg_q    <= FALSE;
            ev_pos_q <= FALSE;
            ev_neg_q <= FALSE;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of the others; blocking would collapse the chain.
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_i};
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            neg_q    <= neg_d;
            ev_pos_q <= ev_pos_d;
            ev_neg_q <= ev_neg_d;
        end
    end

    assign level_o     = level_q;
    assign posedge_o   = pos_q;
    assign negedge_o   = neg_q;
    assign event_pos_o = ev_pos_q;
    assign event_neg_o = ev_neg_q;

endmodule

// File: rtl/edge_detector_multi.sv
// -----------------------------------------------------------------------------
// edge_detector_multi
// NUM_CH independent debounced edge detectors with sticky, software-clearable
// event flags for CPU polling.
// Ports (all vectors NUM_CH wide, bit i belongs to channel i):
//   clk, reset_n  - clock, asynchronous active-low reset
//   in            - raw asynchronous inputs
//   level         - debounced, synchronised levels
//   out_posedge   - one-cycle pulses on accepted 0->1
//   out_negedge   - one-cycle pulses on accepted 1->0
//   event_pos     - sticky posedge flags
//   event_neg     - sticky negedge flags
//   clear_pos     - per-bit clear of event_pos
//   clear_neg     - per-bit clear of event_neg
// -----------------------------------------------------------------------------
module edge_detector_multi
    import edge_detector_multi_pkg::*;
#(
    parameter int   NUM_CH          = 4,
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] in,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] out_posedge,
    output logic [NUM_CH-1:0] out_negedge,
    output logic [NUM_CH-1:0] event_pos,
    output logic [NUM_CH-1:0] event_neg,
    input  logic [NUM_CH-1:0] clear_pos,
    input  logic [NUM_CH-1:0] clear_neg
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT_LEVEL     (INIT_LEVEL)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .in_i       (in[i]),
            .clear_pos_i(clear_pos[i]),
            .clear_neg_i(clear_neg[i]),
            .level_o    (level[i]),
            .posedge_o  (out_posedge[i]),
            .negedge_o  (out_negedge[i]),
            .event_pos_o(event_pos[i]),
            .event_neg_o(event_neg[i])
        );
    end

endmodule

// File: tb/tb_edge_detector_multi.sv
// -----------------------------------------------------------------------------
// tb_edge_detector_multi
// Two instances: dut_a uses the defaults (4 channels, 2 sync stages, 4-cycle
// debounce); dut_b is a single channel with 3 sync stages and no filtering.
// Stimulus pushes the expected pulse (cycle, pulse vectors, level) into a
// per-DUT queue; a monitor per DUT pops and compares whenever a pulse shows.
// -----------------------------------------------------------------------------
module tb_edge_detector_multi;

    typedef struct {
        int         cyc;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] lvl;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;

    logic [3:0] in_a, lvl_a, pos_a, neg_a, evp_a, evn_a, clrp_a, clrn_a;
    logic [0:0] in_b, lvl_b, pos_b, neg_b, evp_b, evn_b, clrp_b, clrn_b;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    edge_detector_multi dut_a (
        .clk        (clk),
        .reset_n    (rst_a_n),
        .in         (in_a),
        .level      (lvl_a),
        .out_posedge(pos_a),
        .out_negedge(neg_a),
        .event_pos  (evp_a),
        .event_neg  (evn_a),
        .clear_pos  (clrp_a),
        .clear_neg  (clrn_a)
    );

    edge_detector_multi #(
        .NUM_CH         (1),
        .SYNC_STAGES    (3),
        .DEBOUNCE_CYCLES(1),
        .INIT_LEVEL     (1'b0)
    ) dut_b (
        .clk        (clk),
        .reset_n    (rst_b_n),
        .in         (in_b),
        .level      (lvl_b),
        .out_posedge(pos_b),
        .out_negedge(neg_b),
        .event_pos  (evp_b),
        .event_neg  (evn_b),
        .clear_pos  (clrp_b),
        .clear_neg  (clrn_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input int lat, input logic [3:0] p, input logic [3:0] n, input logic [3:0] l);
        exp_t e;
        e.cyc = cyc + lat;
        e.pos = p;
        e.neg = n;
        e.lvl = l;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int lat, input logic p, input logic n, input logic l);
        exp_t e;
        e.cyc = cyc + lat;
        e.pos = {3'b000, p};
        e.neg = {3'b000, n};
        e.lvl = {3'b000, l};
        q_b.push_back(e);
    endtask

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_a_n === 1'b1 && (pos_a | neg_a) !== 4'b0000) begin
            check("a_never_both", 32'(pos_a & neg_a), 32'd0);
            if (q_a.size() == 0) begin
                check("a_unexpected_pulse", {24'd0, pos_a, neg_a}, 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_pulse_cycle", cyc, e.cyc);
                check("a_out_posedge", 32'(pos_a), 32'(e.pos));
                check("a_out_negedge", 32'(neg_a), 32'(e.neg));
                check("a_level", 32'(lvl_a), 32'(e.lvl));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_b_n === 1'b1 && (pos_b | neg_b) !== 1'b0) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_pulse", {30'd0, pos_b, neg_b}, 32'd0);
            end else begin
                e = q_b.pop_front();
                check("b_pulse_cycle", cyc, e.cyc);
                check("b_out_posedge", 32'(pos_b), 32'(e.pos));
                check("b_out_negedge", 32'(neg_b), 32'(e.neg));
                check("b_level", 32'(lvl_b), 32'(e.lvl));
            end
        end
    end

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        in_a    = 4'h0;
        in_b    = 1'b0;
        clrp_a  = 4'h0;
        clrn_a  = 4'h0;
        clrp_b  = 1'b0;
        clrn_b  = 1'b0;
        tick(3);
        check("rst_level_a", 32'(lvl_a), 32'd0);
        check("rst_pulses_a", 32'(pos_a | neg_a), 32'd0);
        check("rst_events_a", 32'(evp_a | evn_a), 32'd0);
        check("rst_level_b", 32'(lvl_b), 32'd0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick(2);

        // All channels rise; latency SYNC_STAGES + DEBOUNCE_CYCLES = 6.
        in_a = 4'hF;
        push_a(6, 4'hF, 4'h0, 4'hF);
        tick(8);
        check("all_high_level", 32'(lvl_a), 32'hF);
        check("all_high_evpos", 32'(evp_a), 32'hF);

        // Asynchronous reset in mid-cycle clears state with no clock edge.
        #2 rst_a_n = 1'b0;
        #1;
        check("async_rst_level", 32'(lvl_a), 32'd0);
        check("async_rst_pulses", 32'(pos_a | neg_a), 32'd0);
        check("async_rst_evpos", 32'(evp_a), 32'd0);
        check("async_rst_evneg", 32'(evn_a), 32'd0);
        tick(1);
        rst_a_n = 1'b1;
        push_a(6, 4'hF, 4'h0, 4'hF);
        tick(8);

        in_a = 4'h0;
        push_a(6, 4'h0, 4'hF, 4'h0);
        tick(8);
        check("all_low_evneg", 32'(evn_a), 32'hF);
        clrp_a = 4'hF;
        clrn_a = 4'hF;
        tick(1);
        clrp_a = 4'h0;
        clrn_a = 4'h0;
        check("clear_all_evpos", 32'(evp_a), 32'd0);
        check("clear_all_evneg", 32'(evn_a), 32'd0);

        // Glitch of 3 cycles is filtered; 4 cycles is accepted.
        in_a[0] = 1'b1;
        tick(3);
        in_a[0] = 1'b0;
        tick(8);
        check("glitch3_level", 32'(lvl_a), 32'd0);
        check("glitch3_evpos", 32'(evp_a), 32'd0);
        in_a[0] = 1'b1;
        push_a(6, 4'h1, 4'h0, 4'h1);
        tick(4);
        in_a[0] = 1'b0;
        push_a(6, 4'h0, 4'h1, 4'h0);
        tick(8);

        // Bounce on ch1: 2-cycle segments for 20 cycles, then settle high.
        for (int s = 0; s < 10; s++) begin
            in_a[1] = (s % 2 == 0);
            tick(2);
        end
        in_a[1] = 1'b1;
        push_a(6, 4'h2, 4'h0, 4'h2);
        tick(8);
        check("bounce_level", 32'(lvl_a), 32'h2);
        in_a[1] = 1'b0;
        push_a(6, 4'h0, 4'h2, 4'h0);
        tick(8);
        clrp_a = 4'hF;
        clrn_a = 4'hF;
        tick(1);
        clrp_a = 4'h0;
        clrn_a = 4'h0;

        // Sticky flags on ch2.
        in_a[2] = 1'b1;
        push_a(6, 4'h4, 4'h0, 4'h4);
        tick(8);
        check("sticky_set", 32'(evp_a), 32'h4);
        tick(3);
        check("sticky_hold", 32'(evp_a), 32'h4);
        clrp_a = 4'h4;
        tick(1);
        clrp_a = 4'h0;
        check("sticky_clear", 32'(evp_a), 32'd0);
        in_a[2] = 1'b0;
        push_a(6, 4'h0, 4'h4, 4'h0);
        tick(8);
        check("sticky_neg_set", 32'(evn_a), 32'h4);
        // Clear lands on the same edge as a new set: set wins.
        in_a[2] = 1'b1;
        push_a(6, 4'h4, 4'h0, 4'h4);
        tick(5);
        clrp_a = 4'h4;
        tick(1);
        clrp_a = 4'h0;
        check("set_beats_clear", 32'(evp_a), 32'h4);
        check("sticky_neg_hold", 32'(evn_a), 32'h4);
        in_a[2] = 1'b0;
        push_a(6, 4'h0, 4'h4, 4'h0);
        tick(8);
        clrp_a = 4'hF;
        clrn_a = 4'hF;
        tick(1);
        clrp_a = 4'h0;
        clrn_a = 4'h0;

        // Independence: ch0 rises while preset ch3 falls on the same cycle.
        in_a[3] = 1'b1;
        push_a(6, 4'h8, 4'h0, 4'h8);
        tick(8);
        in_a[0] = 1'b1;
        in_a[3] = 1'b0;
        push_a(6, 4'h1, 4'h8, 4'h1);
        tick(8);
        check("indep_evpos", 32'(evp_a), 32'h9);
        check("indep_evneg", 32'(evn_a), 32'h8);

        // dut_b: SYNC_STAGES=3, DEBOUNCE_CYCLES=1, latency 4.
        in_b = 1'b1;
        push_b(4, 1'b1, 1'b0, 1'b1);
        tick(6);
        check("b_evpos", 32'(evp_b), 32'd1);
        in_b = 1'b0;
        push_b(4, 1'b0, 1'b1, 1'b0);
        tick(6);
        // Reset while the new level is still in the sync chain: no pulse,
        // full latency again after release.
        in_b = 1'b1;
        tick(2);
        #2 rst_b_n = 1'b0;
        #1;
        check("b_rst_evneg", 32'(evn_b), 32'd0);
        tick(1);
        rst_b_n = 1'b1;
        push_b(4, 1'b1, 1'b0, 1'b1);
        tick(6);
        check("b_final_level", 32'(lvl_b), 32'd1);

        tick(4);
        check("a_queue_empty", q_a.size(), 32'd0);
        check("b_queue_empty", q_b.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
